// File: rtl/display_glyph_pkg.sv
// Shared constants for the 7-segment scan decoder: glyph patterns, letter codes,
// digit-base encodings, message words and the decoded message state.
package display_glyph_pkg;

  localparam logic [6:0] GLYPH_S     = 7'h12;
  localparam logic [6:0] GLYPH_T     = 7'h07;
  localparam logic [6:0] GLYPH_P     = 7'h0C;
  localparam logic [6:0] GLYPH_J     = 7'h61;
  localparam logic [6:0] GLYPH_U     = 7'h63;
  localparam logic [6:0] GLYPH_M     = 7'h48;
  localparam logic [6:0] GLYPH_L     = 7'h47;
  localparam logic [6:0] GLYPH_O     = 7'h40;
  localparam logic [6:0] GLYPH_W     = 7'h62;
  localparam logic [6:0] GLYPH_E     = 7'h06;
  localparam logic [6:0] GLYPH_N     = 7'h2B;
  localparam logic [6:0] GLYPH_D     = 7'h01;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  localparam logic [3:0] CODE_S     = 4'h0;
  localparam logic [3:0] CODE_T     = 4'h1;
  localparam logic [3:0] CODE_P     = 4'h2;
  localparam logic [3:0] CODE_J     = 4'h3;
  localparam logic [3:0] CODE_U     = 4'h4;
  localparam logic [3:0] CODE_M     = 4'h5;
  localparam logic [3:0] CODE_L     = 4'h6;
  localparam logic [3:0] CODE_O     = 4'h7;
  localparam logic [3:0] CODE_W     = 4'h8;
  localparam logic [3:0] CODE_E     = 4'h9;
  localparam logic [3:0] CODE_N     = 4'hA;
  localparam logic [3:0] CODE_D     = 4'hB;
  localparam logic [3:0] CODE_ERR   = 4'hE;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  localparam logic [2:0] BASE_D0   = 3'b110;
  localparam logic [2:0] BASE_D1   = 3'b101;
  localparam logic [2:0] BASE_D2   = 3'b011;
  localparam logic [2:0] BASE_IDLE = 3'b111;

  localparam logic [11:0] MSG_STOP  = 12'h012;
  localparam logic [11:0] MSG_JUMP  = 12'h345;
  localparam logic [11:0] MSG_LOW   = 12'h678;
  localparam logic [11:0] MSG_END   = 12'h9AB;
  localparam logic [11:0] MSG_BLANK = 12'hFFF;

  typedef enum logic [2:0] {
    ST_NONE    = 3'd0,
    ST_STOP    = 3'd1,
    ST_JUMP    = 3'd2,
    ST_LOW     = 3'd3,
    ST_END     = 3'd4,
    ST_UNKNOWN = 3'd7
  } msg_state_e;

  function automatic msg_state_e msg_decode(input logic [11:0] word);
    case (word)
      MSG_STOP:  return ST_STOP;
      MSG_JUMP:  return ST_JUMP;
      MSG_LOW:   return ST_LOW;
      MSG_END:   return ST_END;
      MSG_BLANK: return ST_NONE;
      default:   return ST_UNKNOWN;
    endcase
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational reverse lookup: 7-segment glyph to 4-bit letter code.
module seg_glyph_decode
  import display_glyph_pkg::*;
(
  input  logic [6:0] glyph,
  output logic [3:0] code,
  output logic       valid
);

  always_comb begin
    valid = 1'b1;
    case (glyph)
      GLYPH_S:     code = CODE_S;
      GLYPH_T:     code = CODE_T;
      GLYPH_P:     code = CODE_P;
      GLYPH_J:     code = CODE_J;
      GLYPH_U:     code = CODE_U;
      GLYPH_M:     code = CODE_M;
      GLYPH_L:     code = CODE_L;
      GLYPH_O:     code = CODE_O;
      GLYPH_W:     code = CODE_W;
      GLYPH_E:     code = CODE_E;
      GLYPH_N:     code = CODE_N;
      GLYPH_D:     code = CODE_D;
      GLYPH_BLANK: code = CODE_BLANK;
      default: begin
        code  = CODE_ERR;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/display_scan_decoder.sv
// Monitors a multiplexed 3-digit 7-segment bus, recovers letter codes per digit
// and publishes a 12-bit frame once it has repeated STABLE_FRAMES times.
module display_scan_decoder
  import display_glyph_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned STABLE_FRAMES = 2,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic [6:0]  iSegmentos_Display,
  input  logic [2:0]  iBase_Segmentos,
  output logic [11:0] code,
  output logic        code_valid,
  output logic [2:0]  msg_state,
  output logic        glyph_err
);

  localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned SW = $clog2(STABLE_FRAMES + 1);

  logic [9:0]  sync_q [SYNC_STAGES];
  logic [9:0]  sync_d [SYNC_STAGES];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  mask_q, mask_d;
  logic [11:0] frame_q, frame_d;
  logic [11:0] cand_q, cand_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [11:0] code_q, code_d;
  logic        valid_q, valid_d;
  msg_state_e  msg_q, msg_d;
  logic        gerr_q, gerr_d;

  logic [9:0]  bus_cur, bus_nxt;
  logic [6:0]  seg_cur;
  logic [2:0]  base_cur, sel;
  logic        base_legal, capture;
  logic [3:0]  dec_code;
  logic        dec_valid;
  logic [11:0] frame_new;

  seg_glyph_decode u_decode (
    .glyph (seg_cur),
    .code  (dec_code),
    .valid (dec_valid)
  );

  always_comb begin
    sync_d[0] = {iSegmentos_Display, iBase_Segmentos};
    for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  // Change detection looks at the value about to enter the last stage, so the
  // counter is already zero on the first cycle a new bus value is visible.
  assign bus_cur    = sync_q[SYNC_STAGES-1];
  assign bus_nxt    = sync_q[SYNC_STAGES-2];
  assign seg_cur    = bus_cur[9:3];
  assign base_cur   = bus_cur[2:0];
  assign sel        = ~base_cur;
  assign base_legal = (base_cur == BASE_D0) || (base_cur == BASE_D1) || (base_cur == BASE_D2);
  assign capture    = base_legal && (cnt_q == CW'(SETTLE_CYCLES - 1));

  always_comb begin
    frame_new = frame_q;
    for (int unsigned i = 0; i < 3; i++) begin
      if (sel[i]) frame_new[4*i +: 4] = dec_code;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    frame_d  = frame_q;
    cand_d   = cand_q;
    stable_d = stable_q;
    code_d   = code_q;
    valid_d  = 1'b0;
    msg_d    = msg_q;
    gerr_d   = 1'b0;

    if (bus_nxt != bus_cur)                 cnt_d = '0;
    else if (cnt_q != CW'(SETTLE_CYCLES))   cnt_d = cnt_q + 1'b1;

    if (capture) begin
      gerr_d  = ~dec_valid;
      frame_d = frame_new;
      if ((mask_q | sel) == 3'b111) begin
        mask_d = '0;
        if (frame_new == cand_q) begin
          if (stable_q != SW'(STABLE_FRAMES)) stable_d = stable_q + 1'b1;
        end else begin
          cand_d   = frame_new;
          stable_d = SW'(1);
        end
      end else begin
        mask_d = mask_q | sel;
      end
    end else if (!base_legal && base_cur != BASE_IDLE) begin
      mask_d = '0;
    end

    if (stable_q == SW'(STABLE_FRAMES) && cand_q != code_q) begin
      code_d  = cand_q;
      valid_d = 1'b1;
      msg_d   = msg_decode(cand_q);
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= {7'h7F, BASE_IDLE};
      cnt_q    <= '0;
      mask_q   <= '0;
      frame_q  <= '1;
      cand_q   <= '1;
      stable_q <= '0;
      code_q   <= '1;
      valid_q  <= 1'b0;
      msg_q    <= ST_NONE;
      gerr_q   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      frame_q  <= frame_d;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      msg_q    <= msg_d;
      gerr_q   <= gerr_d;
    end
  end

  assign code       = code_q;
  assign code_valid = valid_q;
  assign msg_state  = msg_q;
  assign glyph_err  = gerr_q;

endmodule

// File: tb/tb_display_scan_decoder.sv
// Randomized bench for display_scan_decoder against a frame-level reference model.
module tb_display_scan_decoder;

  localparam int unsigned STABLE = 2;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg;
  logic [2:0]  base;
  logic [11:0] code;
  logic        code_valid;
  logic [2:0]  msg_state;
  logic        glyph_err;

  display_scan_decoder #(
    .SETTLE_CYCLES (16),
    .STABLE_FRAMES (STABLE),
    .SYNC_STAGES   (2)
  ) dut (
    .clk_in             (clk),
    .reset_n            (rst_n),
    .iSegmentos_Display (seg),
    .iBase_Segmentos    (base),
    .code               (code),
    .code_valid         (code_valid),
    .msg_state          (msg_state),
    .glyph_err          (glyph_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int dut_pulses = 0;
  int dut_gerrs  = 0;

  always @(negedge clk) begin
    if (code_valid) dut_pulses++;
    if (glyph_err)  dut_gerrs++;
  end

  // Reference model state
  logic [3:0]  m_frame [3];
  logic [2:0]  m_mask;
  logic [11:0] m_cand;
  int          m_stable;
  logic [11:0] m_code;
  int          m_pulses = 0;
  int          m_gerrs  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_known(input logic [6:0] g);
    return g inside {7'h12, 7'h07, 7'h0C, 7'h61, 7'h63, 7'h48, 7'h47,
                     7'h40, 7'h62, 7'h06, 7'h2B, 7'h01, 7'h7F};
  endfunction

  function automatic logic [3:0] ref_code(input logic [6:0] g);
    case (g)
      7'h12: return 4'h0;  7'h07: return 4'h1;  7'h0C: return 4'h2;
      7'h61: return 4'h3;  7'h63: return 4'h4;  7'h48: return 4'h5;
      7'h47: return 4'h6;  7'h40: return 4'h7;  7'h62: return 4'h8;
      7'h06: return 4'h9;  7'h2B: return 4'hA;  7'h01: return 4'hB;
      7'h7F: return 4'hF;
      default: return 4'hE;
    endcase
  endfunction

  // Inverse table; code E is produced by an out-of-table glyph.
  function automatic logic [6:0] glyph_of(input logic [3:0] c);
    logic [6:0] tbl [16] = '{7'h12, 7'h07, 7'h0C, 7'h61, 7'h63, 7'h48, 7'h47, 7'h40,
                             7'h62, 7'h06, 7'h2B, 7'h01, 7'h55, 7'h55, 7'h55, 7'h7F};
    return tbl[c];
  endfunction

  function automatic logic [2:0] ref_msg(input logic [11:0] w);
    case (w)
      12'h012: return 3'd1;
      12'h345: return 3'd2;
      12'h678: return 3'd3;
      12'h9AB: return 3'd4;
      12'hFFF: return 3'd0;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [2:0] base_of(input int d);
    logic [2:0] b = 3'b111;
    b[d] = 1'b0;
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_frame[i] = 4'hF;
    m_mask = 3'b000; m_cand = 12'hFFF; m_stable = 0; m_code = 12'hFFF;
  endtask

  task automatic model_capture(input int d, input logic [6:0] g);
    logic [11:0] word;
    m_frame[d] = ref_code(g);
    if (!ref_known(g)) m_gerrs++;
    m_mask[d] = 1'b1;
    if (m_mask == 3'b111) begin
      m_mask = 3'b000;
      word = {m_frame[2], m_frame[1], m_frame[0]};
      if (word == m_cand) m_stable = (m_stable < STABLE) ? m_stable + 1 : STABLE;
      else begin
        m_cand = word;
        m_stable = 1;
      end
      if (m_stable == STABLE && m_cand != m_code) begin
        m_code = m_cand;
        m_pulses++;
      end
    end
  endtask

  task automatic dwell(input logic [6:0] s, input logic [2:0] b, input int unsigned n);
    seg  = s;
    base = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_digit(input int d, input logic [3:0] c, input int unsigned n);
    dwell(glyph_of(c), base_of(d), n);
    model_capture(d, glyph_of(c));
  endtask

  task automatic send_frame(input logic [11:0] w, input int reps);
    logic [11:0] wv = w;
    for (int r = 0; r < reps; r++)
      for (int d = 0; d < 3; d++) send_digit(d, wv[4*d +: 4], 40);
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".code"},   32'(code),       32'(m_code));
    check_eq({tag, ".msg"},    32'(msg_state),  32'(ref_msg(m_code)));
    check_eq({tag, ".pulses"}, 32'(dut_pulses), 32'(m_pulses));
    check_eq({tag, ".gerrs"},  32'(dut_gerrs),  32'(m_gerrs));
  endtask

  initial begin
    logic [11:0] words [5] = '{12'h012, 12'h345, 12'h678, 12'h9AB, 12'hFFF};
    logic [3:0]  letters [14] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                  4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hE, 4'hF};
    logic [2:0]  bad_bases [4] = '{3'b000, 3'b001, 3'b010, 3'b100};
    logic [11:0] w;

    seg = 7'h7F; base = 3'b111; rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("reset.code", 32'(code), 32'hFFF);
    check_eq("reset.valid", 32'(code_valid), 32'd0);
    check_eq("reset.msg", 32'(msg_state), 32'd0);
    check_eq("reset.gerr", 32'(glyph_err), 32'd0);
    @(negedge clk);

    dwell(7'h7F, 3'b111, 200);
    check_state("idle");

    send_frame(12'h012, 2);
    check_state("stop");
    check_eq("stop.code_abs", 32'(code), 32'h012);

    send_frame(12'h345, 2);
    check_state("jump");
    send_frame(12'h345, 2);
    check_state("jump_repeat");
    check_eq("jump_repeat.pulses_abs", 32'(dut_pulses), 32'd2);

    // Glitchy digit0: both glitch values are out-of-table, so any capture would pulse glyph_err.
    dwell(7'h7F, 3'b111, 20);
    for (int i = 0; i < 20; i++) dwell((i % 2 == 0) ? 7'h55 : 7'h56, 3'b110, 5);
    check_eq("glitch.gerrs", 32'(dut_gerrs), 32'(m_gerrs));
    dwell(7'h55, 3'b110, 40);
    model_capture(0, 7'h55);
    check_eq("glitch_settled.gerrs", 32'(dut_gerrs), 32'(m_gerrs));
    send_digit(1, 4'h6, 40);
    send_digit(2, 4'h8, 40);
    send_frame(12'h86E, 1);
    check_state("unknown_glyph");
    check_eq("unknown_glyph.msg_abs", 32'(msg_state), 32'd7);

    // Illegal base after two captures drops the partial frame.
    send_digit(0, 4'hB, 40);
    send_digit(1, 4'hA, 40);
    dwell(7'h06, 3'b100, 40);
    m_mask = 3'b000;
    send_digit(2, 4'h9, 40);
    check_state("illegal_partial");
    send_digit(0, 4'hB, 40);
    send_digit(1, 4'hA, 40);
    check_state("illegal_refill");
    send_frame(12'h9AB, 1);
    check_state("illegal_done");

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) != 0) w = words[$urandom_range(0, 4)];
      else for (int d = 0; d < 3; d++) w[4*d +: 4] = letters[$urandom_range(0, 13)];
      dwell(7'h7F, 3'b111, 20);
      for (int r = 0, reps = $urandom_range(1, 3); r < reps; r++) begin
        int start = $urandom_range(0, 2);
        for (int k = 0; k < 3; k++) begin
          int d = (start + k) % 3;
          if ($urandom_range(0, 5) == 0) dwell(7'h7F, 3'b111, $urandom_range(20, 40));
          if ($urandom_range(0, 11) == 0) begin
            dwell(7'h40, bad_bases[$urandom_range(0, 3)], 20);
            m_mask = 3'b000;
          end
          send_digit(d, w[4*d +: 4], $urandom_range(20, 45));
        end
      end
      check_state($sformatf("rand%0d", it));
    end

    // Asynchronous reset between two END frames.
    send_frame(12'h678, 2);
    check_state("pre_reset");
    send_frame(12'h9AB, 1);
    dwell(7'h7F, 3'b111, 7);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("async_reset.code", 32'(code), 32'hFFF);
    check_eq("async_reset.valid", 32'(code_valid), 32'd0);
    check_eq("async_reset.msg", 32'(msg_state), 32'd0);
    check_eq("async_reset.gerr", 32'(glyph_err), 32'd0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    dwell(7'h7F, 3'b111, 10);
    send_frame(12'h9AB, 1);
    check_state("post_reset_1");
    check_eq("post_reset_1.code_abs", 32'(code), 32'hFFF);
    send_frame(12'h9AB, 1);
    check_state("post_reset_2");
    check_eq("post_reset_2.msg_abs", 32'(msg_state), 32'd4);
    dwell(7'h7F, 3'b111, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
